// File: rtl/i2s_tx_24.sv
// I2S transmitter: serialises stereo sample pairs (Philips framing, one-bit delay)
// against an externally generated SCK/WS pair. Optional macro: I2S_TX_UNDERRUN_HOLD_EN.
module i2s_tx_24 #(
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic              sd_o,
    output logic              frame_start_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  underrun_cnt_o
);

    // state | meaning
    // SYNC  | waiting for the first real WS 1->0 transition, line idle
    // LEFT  | shifting out the left slot
    // RIGHT | shifting out the right slot
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam int BC_W  = $clog2(SLOT_BITS);
    localparam int PAD_W = 2 ** BC_W;

    state_t            state, state_nxt;
    logic              sck_q, ws_q;
    logic              fall, ws_fall, ws_rise;
    logic              load, restart, accept;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l, hold_r, act_l, act_r, chan;
    logic [BC_W-1:0]   bit_cnt;
    logic [PAD_W-1:0]  chan_pad;

    assign fall           = sck_q & ~sck_i;
    assign ws_fall        = ws_q & ~ws_i;
    assign ws_rise        = ~ws_q & ws_i;
    assign sample_ready_o = ~hold_full;
    assign accept         = sample_valid_i & ~hold_full;
    assign chan           = (state == RIGHT) ? act_r : act_l;

    // Bit-reversed, zero-padded channel word so bit_cnt indexes the slot directly.
    for (genvar g = 0; g < PAD_W; g++) begin : g_pad
        if (g < DATA_W) begin : g_bit
            assign chan_pad[g] = chan[DATA_W-1-g];
        end else begin : g_zero
            assign chan_pad[g] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        restart   = 1'b0;
        case (state)
            SYNC: begin
                if (fall && ws_fall) begin
                    load      = 1'b1;
                    restart   = 1'b1;
                    state_nxt = LEFT;
                end
            end
            LEFT: begin
                if (fall && ws_rise) begin
                    restart   = 1'b1;
                    state_nxt = RIGHT;
                end
            end
            RIGHT: begin
                if (fall && ws_fall) begin
                    load      = 1'b1;
                    restart   = 1'b1;
                    state_nxt = LEFT;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q          <= 1'b0;
            ws_q           <= 1'b0;
            sd_o           <= 1'b0;
            frame_start_o  <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
            hold_full      <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            act_l          <= '0;
            act_r          <= '0;
            bit_cnt        <= '0;
        end else begin
            sck_q         <= sck_i;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;

            if (accept) begin
                hold_l    <= left_i;
                hold_r    <= right_i;
                hold_full <= 1'b1;
            end else if (load && hold_full) begin
                hold_full <= 1'b0;
            end

            if (fall) begin
                ws_q <= ws_i;
                if (restart) begin
                    bit_cnt <= '0;
                    sd_o    <= 1'b0;
                end else begin
                    if (bit_cnt != BC_W'(SLOT_BITS - 1)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    sd_o <= (state == SYNC) ? 1'b0 : chan_pad[bit_cnt];
                end
            end

            if (load) begin
                if (hold_full) begin
                    act_l         <= hold_l;
                    act_r         <= hold_r;
                    frame_start_o <= 1'b1;
                end else begin
                    underrun_o <= 1'b1;
                    if (underrun_cnt_o != {CNT_W{1'b1}}) begin
                        underrun_cnt_o <= underrun_cnt_o + 1'b1;
                    end
`ifndef I2S_TX_UNDERRUN_HOLD_EN
                    act_l <= '0;
                    act_r <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_24.sv
// Directed bench for i2s_tx_24: a bench-side SCK/WS generator and slot decoder for the
// default instance, plus a small-parameter instance to reach counter saturation quickly.
module tb_i2s_tx_24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (24-bit, 32-bit slots, 16-bit counter)
    logic        rst_a = 1'b1, sck_a = 1'b0, ws_a = 1'b0, val_a = 1'b0;
    logic [23:0] l_a = '0, r_a = '0;
    logic        rdy_a, sd_a, fs_a, ur_a;
    logic [15:0] ucnt_a;

    // small instance for saturation
    logic        rst_b = 1'b1, sck_b = 1'b0, ws_b = 1'b0, val_b = 1'b0;
    logic [3:0]  l_b = '0, r_b = '0;
    logic        rdy_b, sd_b, fs_b, ur_b;
    logic [3:0]  ucnt_b;

    i2s_tx_24 dut_a (
        .clk_i(clk), .rst_i(rst_a), .sck_i(sck_a), .ws_i(ws_a),
        .left_i(l_a), .right_i(r_a), .sample_valid_i(val_a),
        .sample_ready_o(rdy_a), .sd_o(sd_a), .frame_start_o(fs_a),
        .underrun_o(ur_a), .underrun_cnt_o(ucnt_a)
    );

    i2s_tx_24 #(.DATA_W(4), .SLOT_BITS(5), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .sck_i(sck_b), .ws_i(ws_b),
        .left_i(l_b), .right_i(r_b), .sample_valid_i(val_b),
        .sample_ready_o(rdy_b), .sd_o(sd_b), .frame_start_o(fs_b),
        .underrun_o(ur_b), .underrun_cnt_o(ucnt_b)
    );

    int checks = 0;
    int errors = 0;

    logic        gen_a = 1'b0, gen_b = 1'b0;
    int          idx_a = 0, idx_b = 0;
    logic [31:0] sh_a = '0;
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    int          fs_cnt = 0, ur_cnt = 0, wsf_b = 0;
    logic        sd_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk period: sample outputs at the falling clk edge, then advance the generators.
    // Each decoded slot is 32 rises starting at the rise after its WS edge:
    // bit 31 = trailing pad of the previous slot, [30:7] = word, [6:0] = padding.
    task automatic tick();
        @(negedge clk);
        if (fs_a) fs_cnt++;
        if (ur_a) ur_cnt++;
        if (sd_a) sd_seen = 1'b1;
        if (gen_a) begin
            if (!sck_a) begin
                sh_a  = {sh_a[30:0], sd_a};
                sck_a = 1'b1;
            end else begin
                sck_a = 1'b0;
                if (idx_a == 31) begin
                    idx_a = 0;
                    if (ws_a) rq.push_back(sh_a);
                    else      lq.push_back(sh_a);
                    ws_a = ~ws_a;
                end else begin
                    idx_a++;
                end
            end
        end
        if (gen_b) begin
            if (!sck_b) begin
                sck_b = 1'b1;
            end else begin
                sck_b = 1'b0;
                if (idx_b == 4) begin
                    idx_b = 0;
                    if (ws_b) wsf_b++;
                    ws_b = ~ws_b;
                end else begin
                    idx_b++;
                end
            end
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        while (!rdy_a && n < 2000) begin
            tick();
            n++;
        end
        chk("push_ready", 64'(rdy_a), 64'd1);
        l_a   = l;
        r_a   = r;
        val_a = 1'b1;
        tick();
        val_a = 1'b0;
    endtask

    function automatic logic [31:0] slot(input logic [23:0] w);
        return {1'b0, w, 7'b0};
    endfunction

    initial begin
        int          n;
        logic [23:0] kv;
        logic [23:0] hold_l_exp, hold_r_exp;

        // reset state
        repeat (3) tick();
        chk("rst_sd", 64'(sd_a), 64'd0);
        chk("rst_ready", 64'(rdy_a), 64'd1);
        chk("rst_fs", 64'(fs_a), 64'd0);
        chk("rst_ur", 64'(ur_a), 64'd0);
        chk("rst_ucnt", 64'(ucnt_a), 64'd0);
        rst_a = 1'b0;
        gen_a = 1'b1;

        // valid held high before any WS edge: one accept, then ready stays low
        l_a   = 24'hA5A5A5;
        r_a   = 24'h3C3C3C;
        val_a = 1'b1;
        repeat (20) tick();
        chk("ready_after_accept", 64'(rdy_a), 64'd0);
        val_a = 1'b0;

        n = 0;
        while (!ws_a && n < 400) begin tick(); n++; end
        chk("wait_ws_high", 64'(ws_a), 64'd1);
        n = 0;
        while (ws_a && n < 400) begin tick(); n++; end
        chk("wait_ws_fall", 64'(ws_a), 64'd0);
        chk("sync_sd_idle", 64'(sd_seen), 64'd0);
        chk("sync_no_frame", 64'(fs_cnt), 64'd0);
        lq.delete();
        rq.delete();

        // 8-pair stream, then a last pair, then starve the input
        for (int k = 1; k <= 8; k++) begin
            kv = 24'(k);
            push(kv, -kv);
        end
        push(24'h123456, 24'h654321);
        n = 0;
        while (rq.size() < 11 && n < 4000) begin tick(); n++; end
        chk("stream_slots", 64'(rq.size() >= 11 && lq.size() >= 11), 64'd1);
        if (rq.size() >= 11 && lq.size() >= 11) begin
            chk("first_left", 64'(lq[0]), 64'(slot(24'hA5A5A5)));
            chk("first_right", 64'(rq[0]), 64'(slot(24'h3C3C3C)));
            for (int k = 1; k <= 8; k++) begin
                kv = 24'(k);
                chk($sformatf("stream_left_%0d", k), 64'(lq[k]), 64'(slot(kv)));
                chk($sformatf("stream_right_%0d", k), 64'(rq[k]), 64'(slot(-kv)));
            end
            chk("last_left", 64'(lq[9]), 64'(slot(24'h123456)));
            chk("last_right", 64'(rq[9]), 64'(slot(24'h654321)));
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            hold_l_exp = 24'h123456;
            hold_r_exp = 24'h654321;
`else
            hold_l_exp = 24'h0;
            hold_r_exp = 24'h0;
`endif
            chk("underrun_left", 64'(lq[10]), 64'(slot(hold_l_exp)));
            chk("underrun_right", 64'(rq[10]), 64'(slot(hold_r_exp)));
        end
        chk("frame_starts", 64'(fs_cnt), 64'd10);
        chk("underrun_pulses", 64'(ur_cnt), 64'd1);
        chk("underrun_cnt_1", 64'(ucnt_a), 64'd1);

        // reset in the middle of a left slot carrying all-ones
        push(24'hFFFFFF, 24'h800001);
        push(24'h0F0F0F, 24'hF0F0F0);
        n = 0;
        while (!(ws_a == 1'b0 && idx_a == 12) && n < 400) begin tick(); n++; end
        chk("pre_rst_sd", 64'(sd_a), 64'd1);
        chk("pre_rst_ready", 64'(rdy_a), 64'd0);
        chk("pre_rst_ucnt", 64'(ucnt_a), 64'd2);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_sd", 64'(sd_a), 64'd0);
        chk("mid_rst_ready", 64'(rdy_a), 64'd1);
        chk("mid_rst_ucnt", 64'(ucnt_a), 64'd0);
        tick();
        tick();
        rst_a = 1'b0;
        lq.delete();
        rq.delete();
        fs_cnt = 0;
        ur_cnt = 0;
        push(24'h5A5A5A, 24'hC3C3C3);
        n = 0;
        while (rq.size() < 2 && n < 1000) begin tick(); n++; end
        chk("resume_slots", 64'(rq.size() >= 2 && lq.size() >= 2), 64'd1);
        if (rq.size() >= 2 && lq.size() >= 2) begin
            chk("resume_sync_right", 64'(rq[0]), 64'd0);
            chk("resume_left", 64'(lq[1]), 64'(slot(24'h5A5A5A)));
            chk("resume_right", 64'(rq[1]), 64'(slot(24'hC3C3C3)));
        end
        chk("resume_frames", 64'(fs_cnt), 64'd1);
        chk("resume_ucnt", 64'(ucnt_a), 64'd0);

        // saturation on the small instance: every frame underruns
        rst_b = 1'b0;
        gen_b = 1'b1;
        n = 0;
        while (wsf_b < 5 && n < 1000) begin tick(); n++; end
        repeat (2) tick();
        chk("sat_cnt_5", 64'(ucnt_b), 64'd5);
        n = 0;
        while (wsf_b < 20 && n < 1000) begin tick(); n++; end
        repeat (2) tick();
        chk("sat_cnt_20", 64'(ucnt_b), 64'hF);
        n = 0;
        while (wsf_b < 22 && n < 1000) begin tick(); n++; end
        repeat (2) tick();
        chk("sat_cnt_22", 64'(ucnt_b), 64'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
